// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-stream UART TX path between NUM_SRC sources.
// Optional AXIS_ARB_HDR_EN: emits a one-beat owner header {1'b1, index} ahead of each packet.
module axis_uart_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*DATA_BITS-1:0]   s_axis_data,
  input  logic [NUM_SRC-1:0]             s_axis_valid,
  input  logic [NUM_SRC-1:0]             s_axis_last,
  output logic [NUM_SRC-1:0]             s_axis_ready,
  output logic [DATA_BITS-1:0]           m_axis_data,
  output logic                           m_axis_valid,
  output logic                           m_axis_last,
  input  logic                           m_axis_ready,
  output logic [NUM_SRC-1:0]             grant,
  output logic                           busy,
  output logic                           trunc
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_SRC - 1);

  // state  | meaning
  // S_IDLE | no owner; arbitrate among valid sources (one-cycle bubble)
  // S_HDR  | emit owner header beat (only with AXIS_ARB_HDR_EN)
  // S_XFER | pass the owner's stream through until the last handshake
`ifdef AXIS_ARB_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t               state_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 trunc_q;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic                 lim_hit;
  logic                 hs;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_SRC);
      if (!sel_found && s_axis_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign lim_hit = (MAX_BEATS != 0) && (cnt_q == CNT_LIM);

  always_comb begin
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    case (state_q)
`ifdef AXIS_ARB_HDR_EN
      S_HDR: begin
        m_axis_valid               = 1'b1;
        m_axis_data[DATA_BITS-1]   = 1'b1;
        m_axis_data[IDX_W-1:0]     = owner_q;
      end
`endif
      S_XFER: begin
        m_axis_data           = s_axis_data[owner_q*DATA_BITS +: DATA_BITS];
        m_axis_valid          = s_axis_valid[owner_q];
        m_axis_last           = s_axis_last[owner_q] | lim_hit;
        s_axis_ready[owner_q] = m_axis_ready;
      end
      default: ;
    endcase
  end

  assign hs = m_axis_valid & m_axis_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            grant_q <= NUM_SRC'(1) << sel_idx;
            owner_q <= sel_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef AXIS_ARB_HDR_EN
            state_q <= S_HDR;
`else
            state_q <= S_XFER;
`endif
          end
        end
`ifdef AXIS_ARB_HDR_EN
        S_HDR: begin
          if (hs) state_q <= S_XFER;
        end
`endif
        S_XFER: begin
          if (hs) begin
            if (m_axis_last) begin
              state_q <= S_IDLE;
              ptr_q   <= owner_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              // Limit forced the end while the source still had more to send.
              trunc_q <= lim_hit & ~s_axis_last[owner_q];
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign trunc = trunc_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: queued AXIS sources, expected-beat queue, negedge monitor.
module tb_axis_uart_tx_arbiter;

  localparam int NS = 4;
  localparam int DB = 8;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS*DB-1:0]  s_axis_data = '0;
  logic [NS-1:0]     s_axis_valid = '0;
  logic [NS-1:0]     s_axis_last = '0;
  logic [NS-1:0]     s_axis_ready;
  logic [DB-1:0]     m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_last;
  logic              m_axis_ready = 1'b1;
  logic [NS-1:0]     grant;
  logic              busy;
  logic              trunc;

  axis_uart_tx_arbiter #(.NUM_SRC(NS), .DATA_BITS(DB), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .grant(grant), .busy(busy), .trunc(trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    logic          last;
    int            src;
    bit            hdr;
    bit            trc;
  } exp_t;

  typedef logic [DB:0] beat_t;   // {last, data}

  exp_t  exp_q[$];
  beat_t src_q [NS][$];
  bit    rdy_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send_pkt(input int src, input int n, input logic [DB-1:0] base);
    logic [DB-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + DB'(k);
      src_q[src].push_back({(k == n - 1), d});
    end
  endtask

  // Expected beats base+first .. base+first+count-1 from src; lst/trc apply to the final one.
  task automatic exp_pkt(input int src, input logic [DB-1:0] base, input int first,
                         input int count, input bit lst, input bit trc);
    exp_t e;
`ifdef AXIS_ARB_HDR_EN
    e.data = DB'(8'h80 | src); e.last = 1'b0; e.src = src; e.hdr = 1'b1; e.trc = 1'b0;
    exp_q.push_back(e);
`endif
    for (int j = 0; j < count; j++) begin
      e.data = base + DB'(first + j);
      e.last = (j == count - 1) && lst;
      e.src  = src;
      e.hdr  = 1'b0;
      e.trc  = (j == count - 1) && trc;
      exp_q.push_back(e);
    end
  endtask

  task automatic refresh_src();
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_axis_valid[i]        = 1'b1;
        s_axis_data[i*DB +: DB] = b[DB-1:0];
        s_axis_last[i]         = b[DB];
      end else begin
        s_axis_valid[i]        = 1'b0;
        s_axis_data[i*DB +: DB] = '0;
        s_axis_last[i]         = 1'b0;
      end
    end
  endtask

  // Source/sink driver: handshakes sampled at the edge, new values driven 1 time unit later.
  initial begin
    logic [NS-1:0] hs_src;
    forever begin
      @(posedge clk);
      hs_src = s_axis_valid & s_axis_ready;
      #1;
      for (int i = 0; i < NS; i++)
        if (hs_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      refresh_src();
      m_axis_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end
  end

  // Monitor
  initial begin
    bit            stall_p = 0;
    bit            last_p  = 0;
    bit            exp_tn  = 0;
    logic [DB-1:0] hold_d  = '0;
    logic          hold_l  = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_p = 0; last_p = 0; exp_tn = 0;
      end else begin
        chk("trunc_pulse", trunc, exp_tn);
        exp_tn = 0;
        if (last_p) chk("gap_valid", m_axis_valid, 1'b0);
        last_p = 0;
        if (stall_p) begin
          chk("stall_valid", m_axis_valid, 1'b1);
          chk("stall_data", m_axis_data, hold_d);
          chk("stall_last", m_axis_last, hold_l);
        end
        stall_p = 0;
        if (m_axis_valid && !m_axis_ready) begin
          stall_p = 1; hold_d = m_axis_data; hold_l = m_axis_last;
          if (grant != '0 && s_axis_ready != '0) chk("stall_ready", s_axis_ready, '0);
        end
        if (m_axis_valid && m_axis_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b grant 0x%0h, expected none",
                     m_axis_data, m_axis_last, grant);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis_data, e.data);
            chk("beat_last", m_axis_last, e.last);
            chk("beat_grant", grant, NS'(1) << e.src);
            chk("beat_ready", s_axis_ready, e.hdr ? '0 : (NS'(1) << e.src));
            exp_tn = e.trc;
            last_p = m_axis_last;
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_trunc"}, trunc, 1'b0);
    chk({tag, "_sready"}, s_axis_ready, '0);
    chk({tag, "_mvalid"}, m_axis_valid, 1'b0);
    chk({tag, "_mlast"}, m_axis_last, 1'b0);
    chk({tag, "_mdata"}, m_axis_data, '0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    rdy_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d beats still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_settled(input string name);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_busy_end"}, busy, 1'b0);
    chk({name, "_grant_end"}, grant, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single source, 3-beat packet.
    reset_dut();
    send_pkt(1, 3, 8'hA1);
    exp_pkt(1, 8'hA1, 0, 3, 1, 0);
    release_rst();
    #1 chk("t1_grant_before", grant, '0);
    @(negedge clk); #1;
    chk("t1_grant", grant, 4'b0010);
    chk("t1_busy", busy, 1'b1);
    wait_drain("t1", 50);
    @(negedge clk); #1;
    chk("t1_busy_fall", busy, 1'b0);
    check_settled("t1");

    // Contention: sources 0 and 2 valid at reset exit.
    reset_dut();
    send_pkt(0, 2, 8'hB0);
    send_pkt(2, 2, 8'hC0);
    exp_pkt(0, 8'hB0, 0, 2, 1, 0);
    exp_pkt(2, 8'hC0, 0, 2, 1, 0);
    release_rst();
    wait_drain("t2", 50);
    check_settled("t2");

    // Round-robin among 0,1,3 with 1-beat packets.
    reset_dut();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 1, DB'(8'h10 + p));
      send_pkt(1, 1, DB'(8'h20 + p));
      send_pkt(3, 1, DB'(8'h40 + p));
    end
    for (int p = 0; p < 3; p++) begin
      exp_pkt(0, DB'(8'h10 + p), 0, 1, 1, 0);
      exp_pkt(1, DB'(8'h20 + p), 0, 1, 1, 0);
      exp_pkt(3, DB'(8'h40 + p), 0, 1, 1, 0);
    end
    release_rst();
    wait_drain("t3", 100);
    check_settled("t3");

    // Backpressure during a 4-beat packet.
    reset_dut();
    send_pkt(1, 4, 8'hD0);
    exp_pkt(1, 8'hD0, 0, 4, 1, 0);
    release_rst();
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wait_drain("t4", 60);
    check_settled("t4");

    // Beat limit: 20-beat packet cut at 16, remainder re-arbitrated.
    reset_dut();
    send_pkt(0, 20, 8'h00);
    exp_pkt(0, 8'h00, 0, MB, 1, 1);
    exp_pkt(0, 8'h00, MB, 20 - MB, 1, 0);
    release_rst();
    wait_drain("t5", 200);
    check_settled("t5");

    // Reset after beat 2 of 5, then source 0 regains priority over source 3.
    reset_dut();
    send_pkt(0, 5, 8'h50);
    exp_pkt(0, 8'h50, 0, 2, 0, 0);
    release_rst();
    wait_drain("t6a", 50);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("t6_midrst");
    for (int i = 0; i < NS; i++) src_q[i].delete();
    send_pkt(3, 1, 8'h33);
    send_pkt(0, 1, 8'h60);
    exp_pkt(0, 8'h60, 0, 1, 1, 0);
    exp_pkt(3, 8'h33, 0, 1, 1, 0);
    release_rst();
    wait_drain("t6b", 50);
    check_settled("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-stream UART transmit path between NUM_SRC requesters.
- Sits in front of the top_axis_uart AXI-stream input (axis_data/axis_valid/axis_last).
- A grant is held for a whole packet, from grant to the handshake with last, so bytes from different sources never interleave on the serial line.
- A beat limit stops any single requester from holding the transmitter indefinitely.

Parameters:
- NUM_SRC, 4, number of requesting streams (2..8).
- DATA_BITS, 8, stream data width; must match the UART DATA_BITS.
- MAX_BEATS, 16, maximum payload beats per grant; 0 = unlimited.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_data  in  NUM_SRC*DATA_BITS  source data; source i occupies bits [i*DATA_BITS +: DATA_BITS].
- s_axis_valid  in  NUM_SRC  per-source valid.
- s_axis_last  in  NUM_SRC  per-source end-of-packet.
- s_axis_ready  out  NUM_SRC  per-source ready.
- m_axis_data  out  DATA_BITS  data to UART transmitter.
- m_axis_valid  out  1  valid to UART transmitter.
- m_axis_last  out  1  end-of-packet to UART transmitter.
- m_axis_ready  in  1  ready from UART transmitter.
- grant  out  NUM_SRC  one-hot current owner; all-zero when idle.
- busy  out  1  high while any grant is held.
- trunc  out  1  one-cycle pulse when a packet is cut at MAX_BEATS.

Behaviour:
- Reset values: state=IDLE, grant=0, busy=0, trunc=0, s_axis_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0, beat count=0.
- Reset sets the round-robin pointer (last owner) to NUM_SRC-1, so source 0 has first priority.
- State IDLE:
  - All ready outputs low; m_axis_valid low.
  - If any s_axis_valid is high, select the first asserted source searching upward from pointer+1, with modulo NUM_SRC wrap.
  - Register the selection into grant and move to XFER (HDR when the feature is enabled). One-cycle arbitration bubble.
- State XFER (owner g): combinational pass-through.
  - m_axis_data = s_axis_data[g].
  - m_axis_valid = s_axis_valid[g].
  - s_axis_ready[g] = m_axis_ready; all other ready outputs are 0.
  - m_axis_last = s_axis_last[g] OR (MAX_BEATS!=0 AND count==MAX_BEATS-1).
- Handshake = m_axis_valid & m_axis_ready. Each handshake increments count.
- Handshake with m_axis_last=1:
  - Next state IDLE; pointer <= g; grant <= 0; count <= 0.
  - trunc pulses for one cycle if the limit forced last while s_axis_last[g] was 0. The rest of that source's packet is re-arbitrated as a new packet.
- The owner dropping valid mid-packet does not release the grant; the arbiter waits indefinitely.
- Requests from other sources during XFER are ignored until the return to IDLE. Minimum gap between packets is one cycle (the IDLE cycle).
- m_axis_valid never depends on m_axis_ready.
- Once m_axis_valid is high, data and last are held stable until the handshake, provided the source obeys AXIS.
- Reset mid-packet: immediate return to reset values. The partial packet is abandoned; no recovery is required.
- With NUM_SRC=1 the arbiter degenerates to a pass-through with a one-cycle bubble per packet.

Optional Feature:
- Macro AXIS_ARB_HDR_EN.
- Defined:
  - After arbitration, enter HDR for one beat before XFER.
  - Drive m_axis_valid=1, m_axis_data = {1'b1, owner index} zero-extended to DATA_BITS (e.g. source 2 with DATA_BITS=8 gives 8'h82), m_axis_last=0.
  - All s_axis_ready stay 0 during HDR.
  - On handshake go to XFER. The header does not count toward MAX_BEATS.
- Undefined: the HDR state and its logic are absent; IDLE goes straight to XFER.

Test Plan:
- Single source: source 1 sends 3-beat packet A1,A2,A3 (last on A3) with m_axis_ready=1 -> grant=4'b0010 one cycle after valid; output A1,A2,A3 on consecutive cycles with last on A3; busy falls the cycle after.
- Contention: sources 0 and 2 both valid at reset exit, each with a 2-beat packet -> source 0 served first, then source 2; no interleaving; one idle cycle between packets.
- Round-robin fairness: sources 0,1,3 continuously valid with 1-beat packets -> grant order 0,1,3,0,1,3; source 2 is never granted.
- Backpressure: m_axis_ready toggles 1,0,0,1 during a 4-beat packet -> data and last held stable while stalled; the owner's ready mirrors m_axis_ready; all 4 beats delivered in order.
- Beat limit: MAX_BEATS=16, source 0 sends 20 beats with last on beat 20 -> m_axis_last forced on beat 16 and trunc pulses once; re-arbitration follows, then beats 17-20 are sent with last on 20.
- Reset mid-packet, plus header mode: assert rst after beat 2 of 5 -> all outputs return to 0 next cycle and source 0 has priority again. With AXIS_ARB_HDR_EN defined, a source 3 packet is preceded by header 8'h83 with last=0.
